// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - state encoding, port indices and strobe level for sram_arbiter
package sram_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic CPU_PORT = 1'b0;
    localparam logic LDR_PORT = 1'b1;

    // All SRAM strobes and byte enables are active-low.
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side bundle (CPU and loader) of sram_arbiter
interface sram_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;

    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ldr_ack;

    logic [7:0]  rdata;
    logic        busy;
    logic        grant;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output cpu_ack, ldr_ack, rdata, busy, grant
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  cpu_ack, ldr_ack, rdata, busy, grant
    );

endinterface

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner selection; round-robin with SRAM_ARB_RR_EN, else loader-first fixed priority
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_grant,
    output logic winner
);

`ifdef SRAM_ARB_RR_EN
    // On a tie the requester that did not own the last transaction wins.
    always_comb begin
        winner = CPU_PORT;
        if (cpu_req && ldr_req) begin
            winner = ~last_grant;
        end else if (ldr_req) begin
            winner = LDR_PORT;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    assign winner = ldr_req ? LDR_PORT : CPU_PORT;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester async SRAM arbiter; SRAM_ARB_RR_EN selects round-robin arbitration
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
)(
    input  logic          clock,
    input  logic          resetn,
    sram_arbiter_if.slave req_if,
    output logic          sram_chip_enablen,
    output logic          sram_write_enablen,
    output logic          sram_output_enablen,
    output logic          sram_upper_byte,
    output logic          sram_lower_byte,
    output logic [15:0]   address,
    inout  wire  [7:0]    sram_data
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        owner;
    logic        we_l;
    logic [15:0] addr_l;
    logic [7:0]  wdata_l;
    logic [7:0]  rdata_q;
    logic        winner;
    logic        in_access;
    logic        drive_bus;

    sram_arb_pick u_pick (
        .cpu_req    (req_if.cpu_req),
        .ldr_req    (req_if.ldr_req),
        .last_grant (owner),
        .winner     (winner)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            owner   <= CPU_PORT;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Requester inputs are latched here; later changes do not affect this transaction.
                    if (req_if.cpu_req || req_if.ldr_req) begin
                        owner   <= winner;
                        we_l    <= (winner == LDR_PORT) ? req_if.ldr_we    : req_if.cpu_we;
                        addr_l  <= (winner == LDR_PORT) ? req_if.ldr_addr  : req_if.cpu_addr;
                        wdata_l <= (winner == LDR_PORT) ? req_if.ldr_wdata : req_if.cpu_wdata;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt   <= CNT_LOAD;
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt == 4'd1) begin
                        if (!we_l) begin
                            rdata_q <= sram_data;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset releases them immediately.
    assign in_access           = (state == ST_ACCESS);
    assign sram_chip_enablen   = ~in_access;
    assign sram_lower_byte     = ~in_access;
    assign sram_upper_byte     = STROBE_OFF;
    assign sram_write_enablen  = ~(in_access && we_l);
    assign sram_output_enablen = ~(in_access && !we_l);
    assign address             = addr_l;

    assign drive_bus = we_l && ((state == ST_SETUP) || (state == ST_ACCESS));
    assign sram_data = drive_bus ? wdata_l : 8'bz;

    assign req_if.cpu_ack = (state == ST_DONE) && (owner == CPU_PORT);
    assign req_if.ldr_ack = (state == ST_DONE) && (owner == LDR_PORT);
    assign req_if.rdata   = rdata_q;
    assign req_if.busy    = (state != ST_IDLE);
    assign req_if.grant   = owner;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with SRAM model and reference memory
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int AC = 2;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    sram_arbiter_if bus ();

    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [15:0] address;
    wire  [7:0]  sram_data;

    sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clock               (clock),
        .resetn              (resetn),
        .req_if              (bus),
        .sram_chip_enablen   (ce_n),
        .sram_write_enablen  (we_n),
        .sram_output_enablen (oe_n),
        .sram_upper_byte     (ub_n),
        .sram_lower_byte     (lb_n),
        .address             (address),
        .sram_data           (sram_data)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } item_t;

    item_t q_cpu[$];
    item_t q_ldr[$];
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] mem [0:65535];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cnt [2];
    logic grant_log[$];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Asynchronous SRAM model: drives on read strobes, stores while write strobes are low.
    initial for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    assign sram_data = (!ce_n && !oe_n) ? mem[address] : 8'bz;
    always @(posedge clock) if (!ce_n && !we_n) mem[address] <= sram_data;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: invariants every cycle, arbitration model on each grant, scoreboard on each ack.
    logic busy_d, cpu_req_d, ldr_req_d, model_last, port, exp_w;
    int t_start, we_cnt, oe_cnt, last_grant_cyc;
    logic [15:0] acc_addr;
    logic [7:0] wr_bus;
    item_t it;
    initial begin
        busy_d = 0; cpu_req_d = 0; ldr_req_d = 0; model_last = CPU_PORT;
        t_start = 0; we_cnt = 0; oe_cnt = 0; last_grant_cyc = -1000; ack_cnt[0] = 0; ack_cnt[1] = 0;
    end
    always @(negedge clock) begin
        if (!resetn) begin
            busy_d = 0; model_last = CPU_PORT; last_grant_cyc = -1000;
        end else begin
            chk("we_oe_exclusive", 32'(!we_n && !oe_n), 0);
            chk("upper_byte_high", 32'(ub_n), 1);
            chk("lower_byte_tracks_ce", 32'(lb_n), 32'(ce_n));
            if (!oe_n) chk("read_bus_undriven", 32'(sram_data), 32'(mem[address]));
            if (bus.busy && !busy_d) begin
                if (cpu_req_d && ldr_req_d) begin
`ifdef SRAM_ARB_RR_EN
                    exp_w = ~model_last;
`else
                    exp_w = LDR_PORT;
`endif
                end else begin
                    exp_w = ldr_req_d ? LDR_PORT : CPU_PORT;
                end
                chk("arb_winner", 32'(bus.grant), 32'(exp_w));
                if (last_grant_cyc >= 0) chk("grant_spacing", 32'((cyc - 1 - last_grant_cyc) >= AC + 3), 1);
                grant_log.push_back(bus.grant);
                model_last = exp_w;
                last_grant_cyc = cyc - 1;
                t_start = cyc - 1;
                we_cnt = 0; oe_cnt = 0;
            end
            if (!we_n) begin we_cnt++; wr_bus = sram_data; end
            if (!oe_n) oe_cnt++;
            if (!ce_n) acc_addr = address;
            if (bus.cpu_ack || bus.ldr_ack) begin
                chk("single_ack", 32'(bus.cpu_ack && bus.ldr_ack), 0);
                port = bus.ldr_ack;
                chk("ack_owner", 32'(port), 32'(model_last));
                chk("ack_latency", 32'(cyc - t_start), AC + 2);
                if ((port ? q_ldr.size() : q_cpu.size()) == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    it = port ? q_ldr.pop_front() : q_cpu.pop_front();
                    chk("access_addr", 32'(acc_addr), 32'(it.addr));
                    if (it.we) begin
                        chk("we_low_cycles", 32'(we_cnt), AC);
                        chk("oe_low_cycles", 32'(oe_cnt), 0);
                        chk("write_bus_data", 32'(wr_bus), 32'(it.wdata));
                        chk("sram_mem_written", 32'(mem[it.addr]), 32'(it.wdata));
                    end else begin
                        chk("oe_low_cycles", 32'(oe_cnt), AC);
                        chk("we_low_cycles", 32'(we_cnt), 0);
                        chk("rdata", 32'(bus.rdata), 32'(it.rdata));
                    end
                end
                ack_cnt[port] = ack_cnt[port] + 1;
            end
            busy_d = bus.busy; cpu_req_d = bus.cpu_req; ldr_req_d = bus.ldr_req;
        end
    end

    task automatic drive(input logic p, input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
        if (p == LDR_PORT) begin
            bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    task automatic set_req(input logic p, input logic req);
        if (p == LDR_PORT) bus.ldr_req = req; else bus.cpu_req = req;
    endtask

    // Issues one transaction; called with the clock just past a rising edge.
    task automatic run_txn(input logic p, input logic we, input logic [15:0] a, input logic [7:0] d,
                           input bit keep_req, input bit drop_early, input bit chk_lat);
        item_t x;
        int start_ack, n, raise_cyc;
        x.we = we; x.addr = a; x.wdata = d; x.rdata = ref_rd(a);
        if (we) ref_mem[a] = d;
        if (p == LDR_PORT) q_ldr.push_back(x); else q_cpu.push_back(x);
        start_ack = ack_cnt[p];
        raise_cyc = cyc;
        drive(p, 1'b1, we, a, d);
        if (drop_early) begin
            @(posedge clock); #2;
            drive(p, 1'b0, ~we, ~a, ~d);
        end
        n = 0;
        while (ack_cnt[p] == start_ack && n < 300) begin
            @(negedge clock); #1;
            n++;
        end
        if (n >= 300) chk("ack_timeout", 32'(n), 0);
        else if (chk_lat) chk("req_to_ack_latency", 32'(cyc - raise_cyc), AC + 2);
        @(posedge clock); #2;
        if (!keep_req) set_req(p, 1'b0);
    endtask

    task automatic run_port_random(input logic p, input int count);
        int gap;
        logic [15:0] base;
        gap = $urandom_range(0, 4);
        base = (p == LDR_PORT) ? 16'h8000 : 16'h0000;
        for (int i = 0; i < count; i++) begin
            repeat (gap) begin @(posedge clock); #2; end
            gap = $urandom_range(0, 4);
            run_txn(p, 1'($urandom), base | 16'($urandom_range(0, 15)), 8'($urandom),
                    (gap == 0) && (i != count - 1), 1'b0, 1'b0);
        end
    endtask

    int base_log, saw_busy, acks_before;
    initial begin
        #200_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(CPU_PORT, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(LDR_PORT, 1'b0, 1'b0, 16'h0, 8'h0);
        #22;
        chk("reset_strobes", 32'({ce_n, we_n, oe_n, ub_n, lb_n}), 32'h1f);
        chk("reset_address", 32'(address), 0);
        chk("reset_rdata", 32'(bus.rdata), 0);
        chk("reset_acks", 32'({bus.cpu_ack, bus.ldr_ack}), 0);
        chk("reset_busy_grant", 32'({bus.busy, bus.grant}), 0);
        @(posedge clock); #2; resetn = 1'b1;
        @(posedge clock); #2;

        run_txn(CPU_PORT, 1'b1, 16'h1234, 8'hA5, 0, 0, 1);
        run_txn(CPU_PORT, 1'b0, 16'h1234, 8'h00, 0, 0, 1);
        run_txn(LDR_PORT, 1'b1, 16'h9ABC, 8'h5A, 0, 0, 1);
        run_txn(LDR_PORT, 1'b0, 16'h9ABC, 8'h00, 0, 0, 1);
        run_txn(CPU_PORT, 1'b0, 16'h0777, 8'h00, 0, 0, 1);

        // Simultaneous held requests: two transactions per requester.
        base_log = grant_log.size();
        fork
            begin
                run_txn(LDR_PORT, 1'b1, 16'h8001, 8'h11, 1, 0, 0);
                run_txn(LDR_PORT, 1'b0, 16'h8001, 8'h00, 0, 0, 0);
            end
            begin
                run_txn(CPU_PORT, 1'b1, 16'h0001, 8'h22, 1, 0, 0);
                run_txn(CPU_PORT, 1'b0, 16'h0001, 8'h00, 0, 0, 0);
            end
        join
        chk("tie_grant_count", 32'(grant_log.size() - base_log), 4);
        if (grant_log.size() - base_log == 4) begin
`ifdef SRAM_ARB_RR_EN
            chk("tie_order", 32'({grant_log[base_log], grant_log[base_log+1], grant_log[base_log+2], grant_log[base_log+3]}), 32'b1010);
`else
            chk("tie_order", 32'({grant_log[base_log], grant_log[base_log+1], grant_log[base_log+2], grant_log[base_log+3]}), 32'b1100);
`endif
        end

        // Request dropped one cycle after being latched.
        run_txn(CPU_PORT, 1'b1, 16'h0042, 8'hC3, 0, 1, 1);
        saw_busy = 0;
        repeat (AC + 5) begin @(negedge clock); if (bus.busy) saw_busy = 1; end
        chk("no_second_txn", 32'(saw_busy), 0);
        @(posedge clock); #2;

        // Reset in the second ACCESS cycle of a read aborts without ack.
        acks_before = ack_cnt[0] + ack_cnt[1];
        drive(CPU_PORT, 1'b1, 1'b0, 16'h0456, 8'h00);
        repeat (3) begin @(posedge clock); #2; end
        chk("abort_in_access", 32'({ce_n, oe_n}), 0);
        resetn = 1'b0;
        #1;
        chk("abort_strobes", 32'({ce_n, we_n, oe_n, ub_n, lb_n}), 32'h1f);
        chk("abort_busy_acks", 32'({bus.busy, bus.cpu_ack, bus.ldr_ack}), 0);
        chk("abort_address", 32'(address), 0);
        set_req(CPU_PORT, 1'b0);
        repeat (2) begin @(posedge clock); #2; end
        resetn = 1'b1;
        repeat (4) begin @(posedge clock); #2; end
        chk("abort_no_ack", 32'(ack_cnt[0] + ack_cnt[1]), 32'(acks_before));
        run_txn(CPU_PORT, 1'b0, 16'h1234, 8'h00, 0, 0, 1);

        fork
            run_port_random(CPU_PORT, 25);
            run_port_random(LDR_PORT, 25);
        join
        repeat (5) @(posedge clock);
        chk("cpu_queue_drained", 32'(q_cpu.size()), 0);
        chk("ldr_queue_drained", 32'(q_ldr.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
